// File: rtl/blink_scheduler.sv
// blink_scheduler: plays a small step table of (delay code, dwell) pairs into the blinker.
// Optional macro BLINK_SCHED_LOOP_EN: wrap to step 0 at end of sequence instead of stopping.
module blink_scheduler #(
  parameter int TICK_DIV = 50000,
  parameter int STEPS    = 8,
  parameter int DWELL_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pause,
  input  logic                     prog_we,
  input  logic [$clog2(STEPS)-1:0] prog_addr,
  input  logic [3:0]               prog_delay,
  input  logic [DWELL_W-1:0]       prog_dwell,
  input  logic                     prog_last,
  output logic [3:0]               delay,
  output logic                     blink_reset,
  output logic                     blink_pause,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(STEPS);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] STEP_MAX  = AW'(STEPS - 1);
`ifdef BLINK_SCHED_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  // A dwell of zero is stretched to one tick so every step is visible.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    if (d == {DWELL_W{1'b0}}) begin
      dwell_load = DWELL_W'(1);
    end else begin
      dwell_load = d;
    end
  endfunction

  logic [1:0]         rst_sync_r;
  logic               rst_n_s;
  state_t             state_r, state_n;
  logic [3:0]         tbl_delay_r [STEPS];
  logic [DWELL_W-1:0] tbl_dwell_r [STEPS];
  logic [STEPS-1:0]   tbl_last_r;
  logic [PW-1:0]      presc_r, presc_n;
  logic [DWELL_W-1:0] dwell_r, dwell_n;
  logic [AW-1:0]      step_r, step_n, entry_idx_s;
  logic [3:0]         delay_r, delay_n;
  logic               blink_reset_r, blink_reset_n;
  logic               blink_pause_r, blink_pause_n;
  logic               done_r, done_n;
  logic               tick_s, step_end_s, last_step_s;
  logic               restart_s, advance_s, seq_end_s, entry_s;

  // Reset assertion is immediate; release is delayed through two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_r[1];

  // Step table; writes land one cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int i = 0; i < STEPS; i++) begin
        tbl_delay_r[i] <= 4'd0;
        tbl_dwell_r[i] <= {DWELL_W{1'b0}};
      end
      tbl_last_r <= {STEPS{1'b0}};
    end else if (prog_we) begin
      tbl_delay_r[prog_addr] <= prog_delay;
      tbl_dwell_r[prog_addr] <= prog_dwell;
      tbl_last_r[prog_addr]  <= prog_last;
    end else begin
      tbl_last_r <= tbl_last_r;
    end
  end

  assign tick_s      = (state_r == RUN) && (presc_r == PRESC_MAX);
  assign step_end_s  = tick_s && (dwell_r == DWELL_W'(1));
  assign last_step_s = tbl_last_r[step_r] || (step_r == STEP_MAX);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; stop beats start beats pause.
  always_comb begin
    state_n   = state_r;
    restart_s = 1'b0;
    advance_s = 1'b0;
    seq_end_s = 1'b0;
    if (stop) begin
      state_n = IDLE;
    end else if (start) begin
      state_n   = RUN;
      restart_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: state_n = IDLE;
        RUN: begin
          if (step_end_s && last_step_s) begin
            seq_end_s = 1'b1;
            state_n   = LOOP_EN ? (pause ? HOLD : RUN) : IDLE;
          end else if (step_end_s) begin
            advance_s = 1'b1;
            state_n   = pause ? HOLD : RUN;
          end else if (pause) begin
            state_n = HOLD;
          end else begin
            state_n = RUN;
          end
        end
        HOLD:    state_n = pause ? RUN : HOLD;
        default: state_n = IDLE;
      endcase
    end
  end

  // Output/datapath next values: step entry, tick countdown, or plain prescaling.
  always_comb begin
    entry_s       = restart_s || advance_s || (seq_end_s && LOOP_EN);
    entry_idx_s   = advance_s ? (step_r + AW'(1)) : {AW{1'b0}};
    step_n        = step_r;
    delay_n       = delay_r;
    presc_n       = presc_r;
    dwell_n       = dwell_r;
    blink_reset_n = 1'b0;
    done_n        = seq_end_s;
    blink_pause_n = (state_n == HOLD);
    if (entry_s) begin
      step_n        = entry_idx_s;
      delay_n       = tbl_delay_r[entry_idx_s];
      dwell_n       = dwell_load(tbl_dwell_r[entry_idx_s]);
      presc_n       = {PW{1'b0}};
      blink_reset_n = 1'b1;
    end else if (tick_s) begin
      presc_n = {PW{1'b0}};
      dwell_n = dwell_r - DWELL_W'(1);
    end else if (state_r == RUN) begin
      presc_n = presc_r + PW'(1);
    end else begin
      presc_n = presc_r;
    end
  end

  // Registered outputs and counters.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      presc_r       <= {PW{1'b0}};
      dwell_r       <= {DWELL_W{1'b0}};
      step_r        <= {AW{1'b0}};
      delay_r       <= 4'd0;
      blink_reset_r <= 1'b0;
      blink_pause_r <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      presc_r       <= presc_n;
      dwell_r       <= dwell_n;
      step_r        <= step_n;
      delay_r       <= delay_n;
      blink_reset_r <= blink_reset_n;
      blink_pause_r <= blink_pause_n;
      done_r        <= done_n;
    end
  end

  assign delay       = delay_r;
  assign blink_reset = blink_reset_r;
  assign blink_pause = blink_pause_r;
  assign step        = step_r;
  assign done        = done_r;
  assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_blink_scheduler.sv
// Scoreboard bench for blink_scheduler: expected step-entry/done events are queued at stimulus time.
module tb_blink_scheduler;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, prog_we = 1'b0, prog_last = 1'b0;
  logic [2:0] prog_addr = 3'd0;
  logic [3:0] prog_delay = 4'd0;
  logic [7:0] prog_dwell = 8'd0;
  logic [3:0] delay;
  logic       blink_reset, blink_pause, busy, done;
  logic [2:0] step;

  typedef struct {
    int         cyc;
    logic       br;
    logic       dn;
    logic [3:0] dl;
    logic [2:0] st;
    logic       bz;
  } evt_t;

  evt_t sb_q[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   c0;
  int   pc;

  blink_scheduler #(.TICK_DIV(TD), .STEPS(8), .DWELL_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_delay(prog_delay),
    .prog_dwell(prog_dwell), .prog_last(prog_last),
    .delay(delay), .blink_reset(blink_reset), .blink_pause(blink_pause),
    .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_evt(input int c, input logic br, input logic dn,
                          input logic [3:0] dl, input logic [2:0] st, input logic bz);
    evt_t e;
    e.cyc = c; e.br = br; e.dn = dn; e.dl = dl; e.st = st; e.bz = bz;
    sb_q.push_back(e);
  endtask

  task automatic sb_sample();
    evt_t e;
    if (blink_reset || done) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", {30'd0, blink_reset, done}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("evt_cyc", cyc, e.cyc);
        check_eq("evt_blink_reset", {31'd0, blink_reset}, {31'd0, e.br});
        check_eq("evt_done", {31'd0, done}, {31'd0, e.dn});
        check_eq("evt_delay", {28'd0, delay}, {28'd0, e.dl});
        check_eq("evt_step", {29'd0, step}, {29'd0, e.st});
        check_eq("evt_busy", {31'd0, busy}, {31'd0, e.bz});
      end
    end
  endtask

  task automatic step_cyc();
    @(posedge clk);
    #1;
    sb_sample();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step_cyc();
  endtask

  task automatic prog(input logic [2:0] a, input logic [3:0] d, input logic [7:0] w, input logic l);
    prog_we = 1'b1; prog_addr = a; prog_delay = d; prog_dwell = w; prog_last = l;
    step_cyc();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step_cyc();
    stop = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step_cyc();
    reset = 1'b1;
    repeat (4) step_cyc();
    check_eq("rst_delay", {28'd0, delay}, 32'd0);
    check_eq("rst_step", {29'd0, step}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_blink_reset", {31'd0, blink_reset}, 32'd0);
    check_eq("rst_blink_pause", {31'd0, blink_pause}, 32'd0);

    // Basic two-step sequence
    prog(3'd0, 4'd3, 8'd2, 1'b0);
    prog(3'd1, 4'd9, 8'd1, 1'b1);
    c0 = cyc;
    push_evt(c0 + 1, 1'b1, 1'b0, 4'd3, 3'd0, 1'b1);
    push_evt(c0 + 9, 1'b1, 1'b0, 4'd9, 3'd1, 1'b1);
`ifdef BLINK_SCHED_LOOP_EN
    for (int k = 0; k < 3; k++) begin
      push_evt(c0 + 13 + 12 * k, 1'b1, 1'b1, 4'd3, 3'd0, 1'b1);
      if (k < 2) push_evt(c0 + 21 + 12 * k, 1'b1, 1'b0, 4'd9, 3'd1, 1'b1);
    end
    pulse_start();
    wait_until(c0 + 5);
    check_eq("basic_mid_busy", {31'd0, busy}, 32'd1);
    check_eq("basic_mid_delay", {28'd0, delay}, 32'd3);
    wait_until(c0 + 30);
    check_eq("loop_busy_held", {31'd0, busy}, 32'd1);
    wait_until(c0 + 40);
    pulse_stop();
    step_cyc();
    check_eq("loop_stop_busy", {31'd0, busy}, 32'd0);
    check_eq("loop_stop_delay", {28'd0, delay}, 32'd3);
    check_eq("loop_stop_step", {29'd0, step}, 32'd0);
`else
    push_evt(c0 + 13, 1'b0, 1'b1, 4'd9, 3'd1, 1'b0);
    pulse_start();
    wait_until(c0 + 5);
    check_eq("basic_mid_busy", {31'd0, busy}, 32'd1);
    check_eq("basic_mid_delay", {28'd0, delay}, 32'd3);
    wait_until(c0 + 16);
    check_eq("basic_end_busy", {31'd0, busy}, 32'd0);
    check_eq("basic_end_delay", {28'd0, delay}, 32'd9);
    check_eq("basic_end_step", {29'd0, step}, 32'd1);
`endif
    check_eq("basic_sb_empty", sb_q.size(), 32'd0);

    // Zero dwell behaves as one tick
    prog(3'd0, 4'd5, 8'd0, 1'b1);
    c0 = cyc;
    push_evt(c0 + 1, 1'b1, 1'b0, 4'd5, 3'd0, 1'b1);
`ifdef BLINK_SCHED_LOOP_EN
    push_evt(c0 + 5, 1'b1, 1'b1, 4'd5, 3'd0, 1'b1);
    pulse_start();
    wait_until(c0 + 7);
    pulse_stop();
`else
    push_evt(c0 + 5, 1'b0, 1'b1, 4'd5, 3'd0, 1'b0);
    pulse_start();
`endif
    wait_until(c0 + 10);
    check_eq("zero_sb_empty", sb_q.size(), 32'd0);

    // Pause for ten cycles during step 0
    prog(3'd0, 4'd3, 8'd2, 1'b0);
    c0 = cyc;
    push_evt(c0 + 1, 1'b1, 1'b0, 4'd3, 3'd0, 1'b1);
    push_evt(c0 + 19, 1'b1, 1'b0, 4'd9, 3'd1, 1'b1);
`ifdef BLINK_SCHED_LOOP_EN
    push_evt(c0 + 23, 1'b1, 1'b1, 4'd3, 3'd0, 1'b1);
`else
    push_evt(c0 + 23, 1'b0, 1'b1, 4'd9, 3'd1, 1'b0);
`endif
    pc = 0;
    pulse_start();
    while (cyc < c0 + 22) begin
      if (blink_pause) pc++;
      pause = (cyc == c0 + 4) || (cyc == c0 + 14);
      step_cyc();
    end
    pause = 1'b0;
    check_eq("pause_len", pc, 32'd10);
`ifdef BLINK_SCHED_LOOP_EN
    wait_until(c0 + 25);
    pulse_stop();
`endif
    wait_until(c0 + 27);
    check_eq("pause_sb_empty", sb_q.size(), 32'd0);

    // Priority: stop+start in RUN, then start+pause from IDLE with table rewrites
    c0 = cyc;
    push_evt(c0 + 1, 1'b1, 1'b0, 4'd3, 3'd0, 1'b1);
    pulse_start();
    wait_until(c0 + 3);
    start = 1'b1; stop = 1'b1;
    step_cyc();
    start = 1'b0; stop = 1'b0;
    check_eq("prio_stop_busy", {31'd0, busy}, 32'd0);
    check_eq("prio_stop_pause", {31'd0, blink_pause}, 32'd0);
    check_eq("prio_stop_delay", {28'd0, delay}, 32'd3);
    c0 = cyc;
    push_evt(c0 + 1, 1'b1, 1'b0, 4'd3, 3'd0, 1'b1);
    push_evt(c0 + 9, 1'b1, 1'b0, 4'd7, 3'd1, 1'b1);
`ifdef BLINK_SCHED_LOOP_EN
    push_evt(c0 + 13, 1'b1, 1'b1, 4'd12, 3'd0, 1'b1);
`else
    push_evt(c0 + 13, 1'b0, 1'b1, 4'd7, 3'd1, 1'b0);
`endif
    start = 1'b1; pause = 1'b1;
    step_cyc();
    start = 1'b0; pause = 1'b0;
    step_cyc();
    check_eq("prio_sp_pause", {31'd0, blink_pause}, 32'd0);
    check_eq("prio_sp_busy", {31'd0, busy}, 32'd1);
    prog(3'd0, 4'd12, 8'd2, 1'b0);
    prog(3'd1, 4'd7, 8'd1, 1'b1);
    wait_until(c0 + 5);
    check_eq("active_not_reread", {28'd0, delay}, 32'd3);
`ifdef BLINK_SCHED_LOOP_EN
    wait_until(c0 + 15);
    pulse_stop();
`endif
    wait_until(c0 + 17);
    check_eq("prio_sb_empty", sb_q.size(), 32'd0);

    // Asynchronous reset mid-RUN, then walk the cleared table to the last index
    prog(3'd0, 4'd3, 8'd2, 1'b0);
    c0 = cyc;
    push_evt(c0 + 1, 1'b1, 1'b0, 4'd3, 3'd0, 1'b1);
    pulse_start();
    wait_until(c0 + 5);
    #3 reset = 1'b0;
    #1;
    check_eq("arst_delay", {28'd0, delay}, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_step", {29'd0, step}, 32'd0);
    check_eq("arst_blink_pause", {31'd0, blink_pause}, 32'd0);
    step_cyc();
    step_cyc();
    reset = 1'b1;
    repeat (3) step_cyc();
    check_eq("arst_idle_busy", {31'd0, busy}, 32'd0);
    c0 = cyc;
    for (int k = 0; k < 8; k++) push_evt(c0 + 1 + TD * k, 1'b1, 1'b0, 4'd0, 3'(k), 1'b1);
`ifdef BLINK_SCHED_LOOP_EN
    push_evt(c0 + 33, 1'b1, 1'b1, 4'd0, 3'd0, 1'b1);
    pulse_start();
    wait_until(c0 + 35);
    pulse_stop();
`else
    push_evt(c0 + 33, 1'b0, 1'b1, 4'd0, 3'd7, 1'b0);
    pulse_start();
`endif
    wait_until(c0 + 38);
    check_eq("cleared_sb_empty", sb_q.size(), 32'd0);
    check_eq("cleared_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/blink_scheduler.md
Name: blink_scheduler

Overview:
- Programmable step sequencer that drives the blinker's delay code, pause and reset inputs from a small step table.
- Each step holds a 4-bit delay code and a dwell time; the block plays the steps in order and stops or loops at the end.
- Sits between the key one-shot logic and the blinker, replacing manual faster/slower adjustment when a sequence is running.

Parameters:
- TICK_DIV, 50000, clk cycles per dwell tick (1 ms at 50 MHz); legal range ≥2.
- STEPS, 8, step table depth; power of two, ≥2.
- DWELL_W, 8, dwell field width in ticks.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin the sequence at step 0.
- stop  in  1  one-cycle pulse: abort to idle.
- pause  in  1  one-cycle pulse: toggles between running and held.
- prog_we  in  1  table write strobe.
- prog_addr  in  log2(STEPS)  table write index.
- prog_delay  in  4  delay code for the step.
- prog_dwell  in  DWELL_W  dwell in ticks; 0 is treated as 1.
- prog_last  in  1  marks the final step of the sequence.
- delay  out  4  delay code to the blinker.
- blink_reset  out  1  one-cycle pulse on every step entry.
- blink_pause  out  1  level; high while held.
- step  out  log2(STEPS)  current step index.
- busy  out  1  high in RUN or HOLD.
- done  out  1  one-cycle pulse when the sequence ends.

Behaviour:
- Reset (async, reset=0):
  - State IDLE; delay=0, blink_reset=0, blink_pause=0, step=0, busy=0, done=0.
  - Prescaler=0, dwell counter=0, table entries cleared (delay 0, dwell 0, last 0).
  - Deassertion is synchronised internally with a 2-flop release.
- FSM states: IDLE, RUN, HOLD.
  - IDLE + start → RUN. On the next edge: step=0, delay=table[0].delay, blink_reset=1 for that cycle, dwell loaded, prescaler=0.
  - RUN + pause → HOLD. Prescaler and dwell are frozen, blink_pause=1 from the next cycle.
  - HOLD + pause → RUN. Counting resumes from the frozen values, blink_pause=0.
  - Any state + stop → IDLE. busy=0, blink_pause=0, delay and step hold their last values, no done pulse.
  - start while in RUN or HOLD restarts at step 0, with the same timing as from IDLE.
  - Priority on simultaneous pulses: stop > start > pause.
- Prescaler:
  - In RUN, counts 0..TICK_DIV-1.
  - tick is asserted on the cycle where count = TICK_DIV-1; the count then wraps to 0.
- Dwell counter:
  - Loaded with max(dwell,1) on step entry; decrements on each tick.
  - When a tick occurs with the counter at 1, the step advances.
  - Step duration is exactly max(dwell,1)·TICK_DIV cycles, measured from the blink_reset pulse to the next blink_reset pulse.
- Advance:
  - If the current entry has last=0 and step<STEPS-1: step+1, load the new entry, blink_reset pulse.
  - Otherwise end of sequence (see Optional Feature).
- Table writes:
  - Accepted in any state and take effect one cycle after prog_we.
  - The currently active step's delay and dwell are not re-read; a write to the active index applies the next time that step is entered.
  - A write and a step entry to the same index on the same cycle: the entry loads the old contents.
- busy is combinational from state. blink_reset, done and delay are registered.

Optional Feature:
- Macro: BLINK_SCHED_LOOP_EN.
- Defined: end of sequence wraps to step 0 with a blink_reset pulse, stays in RUN, and pulses done for one cycle each time the sequence wraps.
- Undefined: end of sequence → IDLE with a done pulse on the same cycle busy falls; delay holds the last step's code.

Test Plan:
Common setup: TICK_DIV=4, STEPS=8.
- Reset: hold reset=0 mid-RUN → all outputs reach their reset values immediately and asynchronously; after release, state is IDLE.
- Basic sequence, loop off: program step0 (delay 3, dwell 2), step1 (delay 9, dwell 1, last=1), then start.
  - delay=3 with blink_reset at cycle 1.
  - delay=9 with blink_reset at cycle 9.
  - done pulse and busy=0 at cycle 13.
- Zero dwell: step0 dwell=0, last=1 → step lasts 4 cycles, same as dwell=1.
- Pause: pause at 3 cycles into step0 (dwell 2), hold 10 cycles, pause again.
  - blink_pause is high for 10 cycles.
  - The step0 → step1 transition is delayed by exactly 10 cycles.
- Priority: stop and start in the same cycle during RUN → IDLE, busy=0; a start and pause in the same cycle from IDLE → RUN with blink_pause=0.
- Loop (BLINK_SCHED_LOOP_EN defined): two-step table → after step1 the block returns to step 0 with blink_reset and done both high; busy stays high; repeat 3 loops.
